// File: rtl/router_pkg.sv
// router_pkg: shared constants and helpers for the mesh router input stage.
//   - route one-hot codes and output port indices
//   - header field offset helpers (derived from DATA_W / HOP_W / VC_W)
//   - build_flit(): assembles a flit at the default geometry (64b, HOP_W=4, 1 VC bit)
package router_pkg;

  localparam int PORT_UP    = 0;
  localparam int PORT_DOWN  = 1;
  localparam int PORT_LEFT  = 2;
  localparam int PORT_RIGHT = 3;
  localparam int PORT_NIC   = 4;
  localparam int NUM_PORTS  = 5;

  localparam logic [NUM_PORTS-1:0] ROUTE_UP    = 5'b00001;
  localparam logic [NUM_PORTS-1:0] ROUTE_DOWN  = 5'b00010;
  localparam logic [NUM_PORTS-1:0] ROUTE_LEFT  = 5'b00100;
  localparam logic [NUM_PORTS-1:0] ROUTE_RIGHT = 5'b01000;
  localparam logic [NUM_PORTS-1:0] ROUTE_NIC   = 5'b10000;

  localparam int PAYLOAD_W = 48;
  localparam int HOPY_LSB  = PAYLOAD_W;

  // Header is MSB-first: vc | xdir | ydir | reserved | hopX | hopY | payload
  function automatic int hopx_lsb(input int hop_w);
    return PAYLOAD_W + hop_w;
  endfunction

  function automatic int vc_lsb(input int data_w, input int vc_w);
    return data_w - vc_w;
  endfunction

  function automatic int xdir_bit(input int data_w, input int vc_w);
    return data_w - vc_w - 1;
  endfunction

  function automatic int ydir_bit(input int data_w, input int vc_w);
    return data_w - vc_w - 2;
  endfunction

  localparam int DEF_DATA_W = 64;
  localparam int DEF_HOP_W  = 4;

  // Reserved bits are left zero.
  function automatic logic [DEF_DATA_W-1:0] build_flit(
    input logic                 vc,
    input logic                 xdir,
    input logic                 ydir,
    input logic [DEF_HOP_W-1:0] hop_x,
    input logic [DEF_HOP_W-1:0] hop_y,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [DEF_DATA_W-1:0] f;
    f = '0;
    f[DEF_DATA_W-1]                  = vc;
    f[DEF_DATA_W-2]                  = xdir;
    f[DEF_DATA_W-3]                  = ydir;
    f[PAYLOAD_W+DEF_HOP_W +: DEF_HOP_W] = hop_x;
    f[HOPY_LSB +: DEF_HOP_W]         = hop_y;
    f[PAYLOAD_W-1:0]                 = payload;
    return f;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: single virtual-channel circular FIFO.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write wdata_i (caller guarantees not full)
//   pop_i        : drop head (caller guarantees not empty)
//   rdata_o      : head entry (no write-to-read bypass)
//   full_o/empty_o : occupancy flags from the registered count
module vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];

  // Pointers are AW bits wide, so they wrap at DEPTH for free.
  always_comb begin
    wr_d  = push_i ? wr_q + AW'(1) : wr_q;
    rd_d  = pop_i  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + (AW+1)'(1);
    if (!push_i && pop_i) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/router_input_port.sv
// router_input_port: mesh router input stage with NUM_VC per-VC FIFOs,
// X-then-Y route computation, hop decrement and round-robin VC selection.
//   clk, reset          : clock, synchronous active-high reset
//   in_si / in_di       : upstream flit valid / data (VC taken from header)
//   in_ri               : per-VC not-full
//   out_so/out_do       : presented head valid / head with hop updated
//   out_route / out_vc  : one-hot output port / VC of presented flit
//   out_grant           : switch takes the presented flit
//   ovf_err             : sticky, set when a flit hits a full VC
//   polarity            : only with ROUTER_INPORT_POLARITY_EN; even/odd VC phase
module router_input_port
  import router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HOP_W  = 4,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4,
  localparam int VC_W  = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_si,
  input  logic [DATA_W-1:0] in_di,
  output logic [NUM_VC-1:0] in_ri,
  output logic              out_so,
  output logic [DATA_W-1:0] out_do,
  output logic [4:0]        out_route,
  output logic [VC_W-1:0]   out_vc,
  input  logic              out_grant,
  output logic              ovf_err
`ifdef ROUTER_INPORT_POLARITY_EN
  ,
  output logic              polarity
`endif
);
  localparam int HOPX_LSB = hopx_lsb(HOP_W);
  localparam int VC_LSB   = vc_lsb(DATA_W, VC_W);
  localparam int XDIR     = xdir_bit(DATA_W, VC_W);
  localparam int YDIR     = ydir_bit(DATA_W, VC_W);

  logic [NUM_VC-1:0]             push, pop, full, empty, elig;
  logic [NUM_VC-1:0][DATA_W-1:0] rdata;
  logic [VC_W-1:0]               in_vc, sel, idx, rr_q, rr_d;
  logic                          found, ovf_q, ovf_d;
  logic [DATA_W-1:0]             head;
  logic [HOP_W-1:0]              hx, hy;

  assign in_vc = in_di[VC_LSB +: VC_W];

`ifdef ROUTER_INPORT_POLARITY_EN
  logic pol_q;
  always_ff @(posedge clk) begin
    if (reset) pol_q <= 1'b0;
    else       pol_q <= ~pol_q;
  end
  assign polarity = pol_q;
`endif

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    // A same-cycle pop does not free a slot for the push: full is from state.
    assign push[v] = in_si && (in_vc == VC_W'(v)) && !full[v];
    assign pop[v]  = found && out_grant && (sel == VC_W'(v));
`ifdef ROUTER_INPORT_POLARITY_EN
    localparam logic VC_POL = 1'(v % 2);
    assign elig[v] = !empty[v] && (VC_POL == pol_q);
`else
    assign elig[v] = !empty[v];
`endif
    vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[v]),
      .pop_i   (pop[v]),
      .wdata_i (in_di),
      .rdata_o (rdata[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  assign in_ri = ~full;

  // Round-robin search from rr_q; VC_W-bit add wraps modulo NUM_VC.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = rr_q + VC_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign head = rdata[sel];
  assign hx   = head[HOPX_LSB +: HOP_W];
  assign hy   = head[HOPY_LSB +: HOP_W];

  // X first, then Y; a zero hop count never reaches the decrement.
  always_comb begin
    out_route = '0;
    out_do    = '0;
    if (found) begin
      out_do = head;
      if (hx != '0) begin
        out_route = head[XDIR] ? ROUTE_LEFT : ROUTE_RIGHT;
        out_do[HOPX_LSB +: HOP_W] = hx - HOP_W'(1);
      end else if (hy != '0) begin
        out_route = head[YDIR] ? ROUTE_DOWN : ROUTE_UP;
        out_do[HOPY_LSB +: HOP_W] = hy - HOP_W'(1);
      end else begin
        out_route = ROUTE_NIC;
      end
    end
  end

  assign out_so  = found;
  assign out_vc  = found ? sel : '0;
  assign ovf_err = ovf_q;

  always_comb begin
    rr_d  = (found && out_grant) ? sel + VC_W'(1) : rr_q;
    ovf_d = ovf_q | (in_si & full[in_vc]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: directed self-checking bench for router_input_port
// at default parameters (64b flits, 2 VCs, depth 4).
module tb_router_input_port;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_si;
  logic [63:0] in_di;
  logic [1:0]  in_ri;
  logic        out_so;
  logic [63:0] out_do;
  logic [4:0]  out_route;
  logic [0:0]  out_vc;
  logic        out_grant;
  logic        ovf_err;
`ifdef ROUTER_INPORT_POLARITY_EN
  logic        polarity;
  int          cyc;
`endif

  int checks = 0;
  int errors = 0;

  router_input_port dut (
    .clk       (clk),
    .reset     (reset),
    .in_si     (in_si),
    .in_di     (in_di),
    .in_ri     (in_ri),
    .out_so    (out_so),
    .out_do    (out_do),
    .out_route (out_route),
    .out_vc    (out_vc),
    .out_grant (out_grant),
    .ovf_err   (ovf_err)
`ifdef ROUTER_INPORT_POLARITY_EN
    ,
    .polarity  (polarity)
`endif
  );

  always #5 clk = ~clk;

`ifdef ROUTER_INPORT_POLARITY_EN
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end
`endif

  // Flit written at the next posedge; returns at the following negedge.
  task automatic push(input logic [63:0] f);
    @(negedge clk);
    in_si = 1'b1;
    in_di = f;
    @(negedge clk);
    in_si = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (in_ri !== 2'b11) begin errors++; $display("FAIL reset_in_ri got %b exp 11", in_ri); end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL reset_out_so got %b exp 0", out_so); end
    checks++; if (out_route !== 5'b0) begin errors++; $display("FAIL reset_route got %b exp 0", out_route); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
    checks++; if (out_do !== 64'h0) begin errors++; $display("FAIL reset_out_do got %h exp 0", out_do); end
    checks++; if (out_vc !== 1'b0) begin errors++; $display("FAIL reset_out_vc got %b exp 0", out_vc); end
    reset = 1'b0;
  endtask

  task automatic test_routing();
    logic [63:0] fin  [5];
    logic [63:0] fexp [5];
    logic [4:0]  rexp [5];
    logic        vexp [5];
    fin[0] = build_flit(1, 0, 0, 4'd3, 4'd1, 48'h123456789ABC);
    fexp[0]= build_flit(1, 0, 0, 4'd2, 4'd1, 48'h123456789ABC); rexp[0] = 5'b01000; vexp[0] = 1;
    fin[1] = build_flit(0, 0, 0, 4'd0, 4'd2, 48'h000000000111);
    fexp[1]= build_flit(0, 0, 0, 4'd0, 4'd1, 48'h000000000111); rexp[1] = 5'b00001; vexp[1] = 0;
    fin[2] = build_flit(0, 0, 0, 4'd0, 4'd0, 48'hDEADBEEFCAFE);
    fexp[2]= fin[2];                                            rexp[2] = 5'b10000; vexp[2] = 0;
    fin[3] = build_flit(1, 1, 0, 4'd1, 4'd0, 48'h0000000A0A0A);
    fexp[3]= build_flit(1, 1, 0, 4'd0, 4'd0, 48'h0000000A0A0A); rexp[3] = 5'b00100; vexp[3] = 1;
    fin[4] = build_flit(0, 0, 1, 4'd0, 4'd1, 48'h0000000B0B0B);
    fexp[4]= build_flit(0, 0, 1, 4'd0, 4'd0, 48'h0000000B0B0B); rexp[4] = 5'b00010; vexp[4] = 0;
    for (int i = 0; i < 5; i++) begin
      push(fin[i]);
      #1;
      checks++; if (out_so !== 1'b1) begin errors++; $display("FAIL route%0d_so got %b exp 1", i, out_so); end
      checks++; if (out_vc !== vexp[i]) begin errors++; $display("FAIL route%0d_vc got %b exp %b", i, out_vc, vexp[i]); end
      checks++; if (out_route !== rexp[i]) begin errors++; $display("FAIL route%0d_route got %b exp %b", i, out_route, rexp[i]); end
      checks++; if (out_do !== fexp[i]) begin errors++; $display("FAIL route%0d_do got %h exp %h", i, out_do, fexp[i]); end
      out_grant = 1'b1;
      @(negedge clk);
      out_grant = 1'b0;
      #1;
      checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL route%0d_popped got so=%b exp 0", i, out_so); end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] f;
    reset_dut();
    out_grant = 1'b0;
    for (int i = 1; i <= 4; i++) push(build_flit(0, 0, 0, 4'd0, 4'd0, 48'(i)));
    #1;
    checks++; if (in_ri !== 2'b10) begin errors++; $display("FAIL full_in_ri got %b exp 10", in_ri); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL full_ovf_early got %b exp 0", ovf_err); end
    push(build_flit(0, 0, 0, 4'd0, 4'd0, 48'h55));
    #1;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_err); end
    for (int i = 1; i <= 4; i++) begin
      f = build_flit(0, 0, 0, 4'd0, 4'd0, 48'(i));
      checks++; if (out_so !== 1'b1 || out_do !== f) begin errors++; $display("FAIL ovf_drain%0d got so=%b %h exp %h", i, out_so, out_do, f); end
      out_grant = 1'b1;
      @(negedge clk);
      out_grant = 1'b0;
      #1;
    end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL ovf_empty got so=%b exp 0", out_so); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_err); end
  endtask

  task automatic test_round_robin();
    logic [63:0] f;
    reset_dut();
    out_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(build_flit(0, 0, 0, 4'd0, 4'd0, 48'(16'h0A00 + i)));
      push(build_flit(1, 0, 0, 4'd0, 4'd0, 48'(16'h0B00 + i)));
    end
    out_grant = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      f = build_flit(1'(k % 2), 0, 0, 4'd0, 4'd0, 48'(((k % 2) ? 16'h0B00 : 16'h0A00) + k / 2));
      checks++; if (out_so !== 1'b1 || out_vc !== 1'(k % 2)) begin errors++; $display("FAIL rr%0d_vc got so=%b vc=%b exp vc=%0d", k, out_so, out_vc, k % 2); end
      checks++; if (out_do !== f) begin errors++; $display("FAIL rr%0d_do got %h exp %h", k, out_do, f); end
      @(negedge clk);
      #1;
    end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL rr_empty got so=%b exp 0", out_so); end
    out_grant = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [63:0] f;
    logic [47:0] expq [3];
    reset_dut();
    out_grant = 1'b0;
    for (int i = 1; i <= 4; i++) push(build_flit(0, 0, 0, 4'd0, 4'd0, 48'(i)));
    // Full VC: pop succeeds, push is dropped.
    @(negedge clk);
    in_si = 1'b1; in_di = build_flit(0, 0, 0, 4'd0, 4'd0, 48'h9); out_grant = 1'b1;
    @(negedge clk);
    in_si = 1'b0; out_grant = 1'b0;
    #1;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL pp_full_ovf got %b exp 1", ovf_err); end
    checks++; if (in_ri !== 2'b11) begin errors++; $display("FAIL pp_cnt3_ri got %b exp 11", in_ri); end
    // Count 3: push and pop together keep the count.
    in_si = 1'b1; in_di = build_flit(0, 0, 0, 4'd0, 4'd0, 48'hA); out_grant = 1'b1;
    @(negedge clk);
    in_si = 1'b0; out_grant = 1'b0;
    #1;
    checks++; if (in_ri !== 2'b11) begin errors++; $display("FAIL pp_cnt_kept_ri got %b exp 11", in_ri); end
    expq[0] = 48'h3; expq[1] = 48'h4; expq[2] = 48'hA;
    for (int i = 0; i < 3; i++) begin
      f = build_flit(0, 0, 0, 4'd0, 4'd0, expq[i]);
      checks++; if (out_so !== 1'b1 || out_do !== f) begin errors++; $display("FAIL pp_drain%0d got so=%b %h exp %h", i, out_so, out_do, f); end
      out_grant = 1'b1;
      @(negedge clk);
      out_grant = 1'b0;
      #1;
    end
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL pp_empty got so=%b exp 0", out_so); end
  endtask

`ifdef ROUTER_INPORT_POLARITY_EN
  task automatic test_polarity();
    int  r;
    logic exp_pol, exp_so;
    reset_dut();
    out_grant = 1'b0;
    push(build_flit(1, 0, 0, 4'd0, 4'd0, 48'h1));
    push(build_flit(1, 0, 0, 4'd0, 4'd0, 48'h2));
    r = 2;
    out_grant = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_pol = cyc[0];
      exp_so  = exp_pol && (r > 0);
      checks++; if (polarity !== exp_pol) begin errors++; $display("FAIL pol%0d got %b exp %b", k, polarity, exp_pol); end
      checks++; if (out_so !== exp_so) begin errors++; $display("FAIL pol%0d_so got %b exp %b", k, out_so, exp_so); end
      if (exp_so) r--;
      @(negedge clk);
      #1;
    end
    out_grant = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; in_si = 1'b0; in_di = '0; out_grant = 1'b0;
    test_reset();
`ifdef ROUTER_INPORT_POLARITY_EN
    test_polarity();
`else
    test_routing();
    test_overflow();
    test_round_robin();
    test_push_pop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
